// File: rtl/cam_pkg.sv
// ============================================================================
// Module      : cam_pkg
// Description : Shared sizes and enums for the CAM match-vector path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

   localparam int CAM_WIDTH  = 16;
   localparam int CAM_ADDR_W = 8;

   typedef enum logic {
      CAM_OP_SET = 1'b0,
      CAM_OP_CLR = 1'b1
   } cam_op_e;

   typedef enum logic {
      CAM_VB_COLLECT = 1'b0,
      CAM_VB_HOLD    = 1'b1
   } cam_vb_state_e;

endpackage

`default_nettype wire

// File: rtl/cam_addr_dec.sv
// ============================================================================
// Module      : cam_addr_dec
// Description : Combinational full-width address to one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_addr_dec
   import cam_pkg::*;
#(
   parameter int WIDTH  = CAM_WIDTH,
   parameter int ADDR_W = CAM_ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  onehot,
   output logic              in_range
);

   // Widened so that addresses beyond WIDTH never alias onto a valid bit.
   logic [31:0] addr_ext;

   assign addr_ext = 32'(addr);
   assign in_range = (addr_ext < 32'(WIDTH));

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_onehot
         assign onehot[i] = (addr_ext == 32'(i));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/cam_vec_builder.sv
// ============================================================================
// Module      : cam_vec_builder
// Description : Accumulates set/clear requests into a match vector and hands
//               the finished vector downstream over valid/ready.
//               Optional macro CAM_VEC_AUTOCLR_EN zeroes the accumulator on
//               every completed handoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_vec_builder
   import cam_pkg::*;
#(
   parameter int WIDTH  = CAM_WIDTH,
   parameter int ADDR_W = CAM_ADDR_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_op,
   input  logic              req_last,
   output logic              vec_valid,
   input  logic              vec_ready,
   output logic [WIDTH-1:0]  vec_data,
   output logic [CNT_W-1:0]  req_cnt,
   output logic              err_range,
   input  logic              err_clr
);

   cam_vb_state_e    state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] dec_onehot;
   logic             dec_in_range;
   logic             accept;
   logic [WIDTH-1:0] acc_upd;

   cam_addr_dec #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_dec (
      .addr     (req_addr),
      .onehot   (dec_onehot),
      .in_range (dec_in_range)
   );

   assign accept = req_valid && (state_q == CAM_VB_COLLECT);

   // Out-of-range decodes to all zeros, so both ops leave acc unchanged.
   assign acc_upd = (cam_op_e'(req_op) == CAM_OP_CLR) ? (acc_q & ~dec_onehot)
                                                      : (acc_q | dec_onehot);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (err_clr) begin
         err_d = 1'b0;
      end
      if (accept && !dec_in_range) begin
         err_d = 1'b1;
      end

      case (state_q)
         CAM_VB_COLLECT: begin
            if (accept) begin
               acc_d = acc_upd;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (req_last) begin
                  vec_d   = acc_upd;
                  state_d = CAM_VB_HOLD;
               end
            end
         end
         CAM_VB_HOLD: begin
            if (vec_ready) begin
               cnt_d   = '0;
               state_d = CAM_VB_COLLECT;
`ifdef CAM_VEC_AUTOCLR_EN
               acc_d   = '0;
`endif
            end
         end
         default: begin
            state_d = CAM_VB_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CAM_VB_COLLECT;
         acc_q   <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == CAM_VB_COLLECT);
   assign vec_valid = (state_q == CAM_VB_HOLD);
   assign vec_data  = vec_q;
   assign req_cnt   = cnt_q;
   assign err_range = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_vec_builder.sv
// ============================================================================
// Module      : tb_cam_vec_builder
// Description : Self-checking bench for cam_vec_builder (honours
//               CAM_VEC_AUTOCLR_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_vec_builder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_addr;
   logic        req_op;
   logic        req_last;
   logic        vec_valid;
   logic        vec_ready;
   logic [15:0] vec_data;
   logic [7:0]  req_cnt;
   logic        err_range;
   logic        err_clr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   cam_vec_builder #(
      .WIDTH  (16),
      .ADDR_W (8),
      .CNT_W  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_op    (req_op),
      .req_last  (req_last),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_data  (vec_data),
      .req_cnt   (req_cnt),
      .err_range (err_range),
      .err_clr   (err_clr)
   );

   typedef struct {
      logic        v;
      logic [7:0]  a;
      logic        op;
      logic        l;
      logic        vr;
      logic        ec;
      logic        e_rdy;
      logic        e_vv;
      logic [15:0] e_vec;
      logic [7:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t tbl[21];

   // Reference model: resident entry table, frame count, handoff flag.
   bit          m_tab[16];
   int          m_cnt;
   bit          m_hold;
   bit          m_err;
   logic [15:0] m_vec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic op,
                        input logic l, input logic vr, input logic ec);
      req_valid = v;
      req_addr  = a;
      req_op    = op;
      req_last  = l;
      vec_ready = vr;
      err_clr   = ec;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic rdy, input logic vv,
                            input logic [15:0] vec, input logic [7:0] cnt, input logic err);
      check({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
      check({tag, " vec_valid"}, 32'(vec_valid), 32'(vv));
      check({tag, " vec_data"},  32'(vec_data),  32'(vec));
      check({tag, " req_cnt"},   32'(req_cnt),   32'(cnt));
      check({tag, " err_range"}, 32'(err_range), 32'(err));
   endtask

   function automatic void model_reset();
      foreach (m_tab[i]) m_tab[i] = 1'b0;
      m_cnt  = 0;
      m_hold = 1'b0;
      m_err  = 1'b0;
      m_vec  = '0;
   endfunction

   function automatic void model_step();
      if (err_clr) m_err = 1'b0;
      if (m_hold) begin
         if (vec_ready) begin
            m_hold = 1'b0;
            m_cnt  = 0;
`ifdef CAM_VEC_AUTOCLR_EN
            foreach (m_tab[i]) m_tab[i] = 1'b0;
`endif
         end
      end else if (req_valid) begin
         if (m_cnt < 255) m_cnt++;
         if (int'(req_addr) < 16) m_tab[int'(req_addr)] = (req_op == 1'b0);
         else m_err = 1'b1;
         if (req_last) begin
            m_hold = 1'b1;
            for (int i = 0; i < 16; i++) m_vec[i] = m_tab[i];
         end
      end
   endfunction

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
   endtask

   logic [15:0] e2;

   initial begin
`ifdef CAM_VEC_AUTOCLR_EN
      e2 = 16'h0000;
`else
      e2 = 16'h0201;
`endif
      //          v   a      op  l   vr  ec  | rdy vv  vec       cnt   err
      tbl[0]  = '{1, 8'd3,  0,  0,  0,  0,   1,  0,  16'h0000, 8'd1, 0};
      tbl[1]  = '{1, 8'd9,  0,  0,  0,  0,   1,  0,  16'h0000, 8'd2, 0};
      tbl[2]  = '{1, 8'd0,  0,  1,  0,  0,   0,  1,  16'h0209, 8'd3, 0};
      for (int i = 3; i < 8; i++)
         tbl[i] = '{1, 8'd7, 0,  1,  0,  0,   0,  1,  16'h0209, 8'd3, 0};
      tbl[8]  = '{0, 8'd0,  0,  0,  1,  0,   1,  0,  16'h0209, 8'd0, 0};
      tbl[9]  = '{1, 8'd3,  1,  1,  0,  0,   0,  1,  e2,       8'd1, 0};
      tbl[10] = '{0, 8'd0,  0,  0,  1,  0,   1,  0,  e2,       8'd0, 0};
      tbl[11] = '{1, 8'd20, 0,  1,  0,  0,   0,  1,  e2,       8'd1, 1};
      tbl[12] = '{0, 8'd0,  0,  0,  1,  0,   1,  0,  e2,       8'd0, 1};
      tbl[13] = '{0, 8'd0,  0,  0,  0,  1,   1,  0,  e2,       8'd0, 0};
      tbl[14] = '{1, 8'd16, 0,  0,  0,  1,   1,  0,  e2,       8'd1, 1};
      tbl[15] = '{1, 8'd9,  1,  0,  0,  0,   1,  0,  e2,       8'd2, 1};
      tbl[16] = '{1, 8'd0,  1,  0,  0,  0,   1,  0,  e2,       8'd3, 1};
      tbl[17] = '{1, 8'd15, 0,  1,  1,  0,   0,  1,  16'h8000, 8'd4, 1};
      tbl[18] = '{1, 8'd15, 0,  1,  1,  0,   1,  0,  16'h8000, 8'd0, 1};
      tbl[19] = '{1, 8'd15, 0,  1,  1,  0,   0,  1,  16'h8000, 8'd1, 1};
      tbl[20] = '{1, 8'd15, 0,  1,  1,  0,   1,  0,  16'h8000, 8'd0, 1};

      rst_n = 1'b0;
      drive(0, 8'd0, 0, 0, 0, 0);
      #12;
      check_all("reset", 1, 0, 16'h0000, 8'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].op, tbl[i].l, tbl[i].vr, tbl[i].ec);
         cycle();
         check_all($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_vv,
                   tbl[i].e_vec, tbl[i].e_cnt, tbl[i].e_err);
      end

      // Counter saturation inside one long frame.
      drive(1, 8'd2, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) cycle();
      check("sat req_cnt", 32'(req_cnt), 32'd255);
      drive(1, 8'd2, 0, 1, 0, 0);
      cycle();
      check("sat hold req_cnt", 32'(req_cnt), 32'd255);
      check("sat hold vec_valid", 32'(vec_valid), 32'd1);
      drive(0, 8'd0, 0, 0, 1, 0);
      cycle();
      check("sat done req_cnt", 32'(req_cnt), 32'd0);

      // Asynchronous reset mid-frame.
      drive(1, 8'd5, 0, 0, 0, 0);
      cycle();
      check("midframe req_cnt", 32'(req_cnt), 32'd1);
      pulse_reset();
      check_all("rst midframe", 1, 0, 16'h0000, 8'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset while holding a vector.
      drive(1, 8'd7, 0, 1, 0, 0);
      cycle();
      check("prehold vec_valid", 32'(vec_valid), 32'd1);
      pulse_reset();
      check_all("rst hold", 1, 0, 16'h0000, 8'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive(1, 8'd1, 0, 1, 0, 0);
      cycle();
      check_all("post rst frame", 0, 1, 16'h0002, 8'd1, 0);
      drive(0, 8'd0, 0, 0, 1, 0);
      cycle();

      // Randomised run against the reference model.
      drive(0, 8'd0, 0, 0, 0, 0);
      pulse_reset();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
         req_op    = 1'($urandom);
         req_last  = ($urandom_range(0, 3) == 0);
         vec_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         model_step();
         #1;
         check_all($sformatf("rand%0d", c), !m_hold, m_hold, m_vec, 8'(m_cnt), m_err);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
